// File: rtl/tpp_pkg.sv
// rtl/tpp_pkg.sv - shared states, symbol ranks and default constants for the TPP encoder (TPP_ENC_EOF_EN adds ST_EOF)
package tpp_pkg;

    localparam int DELIM_LEN_DEF = 24;
    localparam int LOW_W_DEF     = 6;
    localparam int EOF_LEN_DEF   = 320;
    localparam int TCAL2_MIN     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELIM,
        ST_TCAL1,
        ST_TCAL2,
        ST_DATA
`ifdef TPP_ENC_EOF_EN
        ,
        ST_EOF
`endif
    } tpp_state_t;

    // Line shape the segment timer produces while counting.
    typedef enum logic [1:0] {
        SEG_SHAPE,
        SEG_LOW,
        SEG_HIGH
    } seg_mode_t;

    // Gray ordering of the 2-bit data codes onto length ranks.
    function automatic logic [1:0] code_rank(input logic [1:0] code);
        case (code)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/tpp_encoder_if.sv
// rtl/tpp_encoder_if.sv - symbol stream handshake between command assembly and the TPP encoder
interface tpp_encoder_if;
    logic [1:0] sym_data;
    logic       sym_valid;
    logic       sym_last;
    logic       sym_ready;

    modport master (
        output sym_data,
        output sym_valid,
        output sym_last,
        input  sym_ready
    );

    modport slave (
        input  sym_data,
        input  sym_valid,
        input  sym_last,
        output sym_ready
    );
endinterface

// File: rtl/tpp_seg_timer.sv
// rtl/tpp_seg_timer.sv - segment down-counter that shapes the TPP line and flags the segment's last cycle
module tpp_seg_timer
    import tpp_pkg::*;
#(
    parameter int LOW_W = LOW_W_DEF
) (
    input  logic       dec_clk,
    input  logic       rst_n,
    input  logic       ld,
    input  logic [9:0] ld_len,
    input  seg_mode_t  ld_mode,
    input  logic       clr,
    output logic       dout,
    output logic       seg_last,
    output logic       seg_pre
);

    localparam logic [9:0] LOW_W10 = 10'(LOW_W);

    logic [9:0] cnt;
    seg_mode_t  mode;

    // Line level for a given remaining count: high until the final LOW_W cycles.
    function automatic logic shape(input seg_mode_t m, input logic [9:0] n);
        case (m)
            SEG_LOW:  return 1'b0;
            SEG_HIGH: return 1'b1;
            default:  return (n > LOW_W10);
        endcase
    endfunction

    // Clear to idle-high, load a new segment, or count down; dout follows the next count.
    always_ff @(posedge dec_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            mode <= SEG_HIGH;
            dout <= 1'b1;
        end else if (clr) begin
            cnt  <= '0;
            mode <= SEG_HIGH;
            dout <= 1'b1;
        end else if (ld) begin
            cnt  <= ld_len;
            mode <= ld_mode;
            dout <= shape(ld_mode, ld_len);
        end else if (cnt != '0) begin
            cnt  <= cnt - 10'd1;
            dout <= shape(mode, cnt - 10'd1);
        end
    end

    assign seg_last = (cnt == 10'd1);
    assign seg_pre  = (cnt == 10'd2);

endmodule

// File: rtl/tpp_encoder.sv
// rtl/tpp_encoder.sv - TPP frame transmitter: delimiter, Tcal1, Tcal2, 2-bit data symbols (TPP_ENC_EOF_EN adds EOF hold)
module tpp_encoder
    import tpp_pkg::*;
#(
    parameter int DELIM_LEN = DELIM_LEN_DEF,
    parameter int LOW_W     = LOW_W_DEF
`ifdef TPP_ENC_EOF_EN
    ,
    parameter int EOF_LEN   = EOF_LEN_DEF
`endif
) (
    input  logic         dec_clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [8:0]   tcal1,
    input  logic [8:0]   tcal2,
    input  logic         abort,
    tpp_encoder_if.slave sym,
    output logic         dout,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [8:0] LOW_W9     = 9'(LOW_W);
    localparam logic [8:0] TCAL2_MIN9 = 9'(TCAL2_MIN);
    localparam logic [9:0] DELIM10    = 10'(DELIM_LEN);
`ifdef TPP_ENC_EOF_EN
    localparam logic [9:0] TAIL_LEN   = 10'(EOF_LEN);
`else
    localparam logic [9:0] TAIL_LEN   = 10'd1;
`endif

    tpp_state_t state;
    logic [8:0] tcal1_r;
    logic [8:0] tcal2_r;
    logic       last_r;
    logic       tail_r;

    logic       cfg_ok;
    logic       abort_act;
    logic       fetch_next;
    logic [9:0] base;
    logic [9:0] step;
    logic [9:0] sym_len;

    logic       tmr_ld;
    logic       tmr_clr;
    logic [9:0] tmr_len;
    seg_mode_t  tmr_mode;
    logic       seg_last;
    logic       seg_pre;

    assign cfg_ok    = (tcal2 >= TCAL2_MIN9) && (tcal1 > tcal2) && (tcal2 > LOW_W9);
    assign abort_act = abort && (state != ST_IDLE);

    // Data symbols sit between the decoder pivots: base plus rank steps of tcal2/4.
    assign base    = {3'b000, tcal1_r[8:2]} + {4'b0000, tcal2_r[8:3]};
    assign step    = {3'b000, tcal2_r[8:2]};
    assign sym_len = base + step * {8'd0, code_rank(sym.sym_data)};

    // The next cycle is a fetch cycle when a symbol-requesting segment is one count from its end.
    assign fetch_next = seg_pre && ((state == ST_TCAL2) ||
                                    ((state == ST_DATA) && !last_r && !tail_r));

    // Segment timer commands derived from the current state and segment end.
    always_comb begin
        tmr_ld   = 1'b0;
        tmr_clr  = 1'b0;
        tmr_len  = '0;
        tmr_mode = SEG_SHAPE;
        if (abort_act) begin
            tmr_clr = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && cfg_ok) begin
                        tmr_ld   = 1'b1;
                        tmr_len  = DELIM10;
                        tmr_mode = SEG_LOW;
                    end
                end
                ST_DELIM: begin
                    if (seg_last) begin
                        tmr_ld  = 1'b1;
                        tmr_len = {1'b0, tcal1_r};
                    end
                end
                ST_TCAL1: begin
                    if (seg_last) begin
                        tmr_ld  = 1'b1;
                        tmr_len = {1'b0, tcal2_r};
                    end
                end
                ST_TCAL2: begin
                    if (seg_last) begin
                        tmr_ld  = sym.sym_valid;
                        tmr_clr = !sym.sym_valid;
                        tmr_len = sym_len;
                    end
                end
                ST_DATA: begin
                    if (seg_last) begin
                        if (tail_r) begin
                            tmr_clr = 1'b1;
                        end else if (last_r) begin
                            tmr_ld   = 1'b1;
                            tmr_len  = TAIL_LEN;
                            tmr_mode = SEG_HIGH;
                        end else begin
                            tmr_ld  = sym.sym_valid;
                            tmr_clr = !sym.sym_valid;
                            tmr_len = sym_len;
                        end
                    end
                end
`ifdef TPP_ENC_EOF_EN
                ST_EOF: begin
                    if (seg_last) begin
                        tmr_clr = 1'b1;
                    end
                end
`endif
                default: tmr_clr = 1'b1;
            endcase
        end
    end

    tpp_seg_timer #(
        .LOW_W (LOW_W)
    ) u_seg_timer (
        .dec_clk  (dec_clk),
        .rst_n    (rst_n),
        .ld       (tmr_ld),
        .ld_len   (tmr_len),
        .ld_mode  (tmr_mode),
        .clr      (tmr_clr),
        .dout     (dout),
        .seg_last (seg_last),
        .seg_pre  (seg_pre)
    );

    // Frame sequencer with registered busy/done/err/sym_ready; abort overrides everything.
    always_ff @(posedge dec_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            sym.sym_ready <= 1'b0;
            tcal1_r       <= '0;
            tcal2_r       <= '0;
            last_r        <= 1'b0;
            tail_r        <= 1'b0;
        end else begin
            done          <= 1'b0;
            err           <= 1'b0;
            sym.sym_ready <= 1'b0;
            if (abort_act) begin
                state  <= ST_IDLE;
                busy   <= 1'b0;
                tail_r <= 1'b0;
            end else begin
                sym.sym_ready <= fetch_next;
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (cfg_ok) begin
                                tcal1_r <= tcal1;
                                tcal2_r <= tcal2;
                                last_r  <= 1'b0;
                                tail_r  <= 1'b0;
                                busy    <= 1'b1;
                                state   <= ST_DELIM;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    ST_DELIM: if (seg_last) state <= ST_TCAL1;
                    ST_TCAL1: if (seg_last) state <= ST_TCAL2;
                    ST_TCAL2: begin
                        if (seg_last) begin
                            if (sym.sym_valid) begin
                                last_r <= sym.sym_last;
                                state  <= ST_DATA;
                            end else begin
                                err   <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (seg_last) begin
                            if (tail_r) begin
                                tail_r <= 1'b0;
                                done   <= 1'b1;
                                busy   <= 1'b0;
                                state  <= ST_IDLE;
                            end else if (last_r) begin
`ifdef TPP_ENC_EOF_EN
                                state  <= ST_EOF;
`else
                                tail_r <= 1'b1;
`endif
                            end else if (sym.sym_valid) begin
                                last_r <= sym.sym_last;
                            end else begin
                                err   <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end
                    end
`ifdef TPP_ENC_EOF_EN
                    ST_EOF: begin
                        if (seg_last) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
`endif
                    default: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tpp_encoder.sv
// tb/tb_tpp_encoder.sv - self-checking bench for tpp_encoder
module tb_tpp_encoder;

    localparam int DELIM = 24;
    localparam int LOWW  = 6;
`ifdef TPP_ENC_EOF_EN
    localparam int DONE_GAP = 320;
`else
    localparam int DONE_GAP = 1;
`endif

    logic       dec_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic [8:0] tcal1   = '0;
    logic [8:0] tcal2   = '0;
    logic       dout;
    logic       busy;
    logic       done;
    logic       err;

    tpp_encoder_if sif ();

    tpp_encoder dut (
        .dec_clk (dec_clk),
        .rst_n   (rst_n),
        .start   (start),
        .tcal1   (tcal1),
        .tcal2   (tcal2),
        .abort   (abort),
        .sym     (sif),
        .dout    (dout),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 dec_clk = ~dec_clk;

    typedef struct {
        int intv;
        int low;
    } edge_t;

    typedef struct {
        int                  t1;
        int                  t2;
        int                  n;
        logic [3:0][1:0]     code;
        logic [3:0][9:0]     len;
        int                  busy;
    } vec_t;

    typedef struct {
        int t1;
        int t2;
        bit bad;
    } cfg_t;

    edge_t meas_q[$];
    int    exp_q[$];

    int   checks   = 0;
    int   failures = 0;

    int   cyc       = 0;
    logic prev_dout = 1'b1;
    int   last_rise = 0;
    int   last_fall = 0;
    int   rise_cnt  = 0;
    int   done_cnt  = 0;
    int   err_cnt   = 0;
    int   busy_cnt  = 0;
    int   xfer_cnt  = 0;
    int   done_gap  = 0;
    logic err_dout  = 1'b0;
    logic err_busy  = 1'b0;

    always @(posedge dec_clk) cyc <= cyc + 1;

    // Line monitor: measures rising-edge intervals and low widths, counts handshakes and pulses.
    always @(negedge dec_clk) begin
        if (prev_dout === 1'b1 && dout === 1'b0) last_fall = cyc;
        if (prev_dout === 1'b0 && dout === 1'b1) begin
            meas_q.push_back('{intv: cyc - last_rise, low: cyc - last_fall});
            last_rise = cyc;
            rise_cnt++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_gap = cyc - last_rise;
        end
        if (err === 1'b1) begin
            err_cnt++;
            err_dout = dout;
            err_busy = busy;
        end
        if (busy === 1'b1) busy_cnt++;
        if (sif.sym_ready === 1'b1 && sif.sym_valid === 1'b1) xfer_cnt++;
        prev_dout = dout;
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    // Drive one frame; under_at >= 0 withholds sym_valid from that symbol's fetch onward.
    task automatic run_frame(input vec_t v, input int under_at, input string tag);
        int    d0, e0, b0, x0, idx, budget, nexp;
        bit    took, fin;
        edge_t m;
        meas_q.delete();
        exp_q.delete();
        d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt; x0 = xfer_cnt;
        exp_q.push_back(v.t1);
        exp_q.push_back(v.t2);
        for (int i = 0; i < v.n; i++)
            if (under_at < 0 || i < under_at) exp_q.push_back(int'(v.len[i]));
        nexp = exp_q.size();
        tcal1 = 9'(v.t1);
        tcal2 = 9'(v.t2);
        sif.sym_data  = v.code[0];
        sif.sym_last  = (v.n == 1);
        sif.sym_valid = (under_at != 0);
        start = 1'b1;
        @(posedge dec_clk); #1;
        start = 1'b0;
        idx = 0; budget = 0; fin = 1'b0;
        while (!fin && budget < 3000) begin
            @(negedge dec_clk);
            took = sif.sym_ready && sif.sym_valid;
            fin  = !busy;
            @(posedge dec_clk); #1;
            if (took) begin
                idx++;
                if (idx < v.n) begin
                    sif.sym_data  = v.code[idx];
                    sif.sym_last  = (idx == v.n - 1);
                    sif.sym_valid = (idx != under_at);
                end else begin
                    sif.sym_valid = 1'b0;
                end
            end
            budget++;
            start = (budget == 30);
        end
        start = 1'b0;
        sif.sym_valid = 1'b0;
        chk({tag, "_ends_in_budget"}, int'(fin), 1);
        chk({tag, "_edge_count"}, meas_q.size(), nexp + 1);
        if (meas_q.size() > 0) begin
            m = meas_q.pop_front();
            chk({tag, "_delim_low"}, m.low, DELIM);
        end
        while (exp_q.size() > 0 && meas_q.size() > 0) begin
            m = meas_q.pop_front();
            chk({tag, "_seg_len"}, m.intv, exp_q.pop_front());
            chk({tag, "_seg_low"}, m.low, LOWW);
        end
        if (under_at < 0) begin
            chk({tag, "_done_pulses"}, done_cnt - d0, 1);
            chk({tag, "_err_pulses"}, err_cnt - e0, 0);
            chk({tag, "_sym_xfers"}, xfer_cnt - x0, v.n);
            chk({tag, "_busy_len"}, busy_cnt - b0, v.busy + DONE_GAP - 1);
            chk({tag, "_done_gap"}, done_gap, DONE_GAP);
        end else begin
            chk({tag, "_done_pulses"}, done_cnt - d0, 0);
            chk({tag, "_err_pulses"}, err_cnt - e0, 1);
            chk({tag, "_sym_xfers"}, xfer_cnt - x0, under_at);
            chk({tag, "_dout_at_err"}, int'(err_dout), 1);
            chk({tag, "_busy_at_err"}, int'(err_busy), 0);
        end
        repeat (3) @(posedge dec_clk);
        #1;
    endtask

    // Abort while TCAL1 is in its low tail, then restart one cycle later.
    task automatic abort_seq();
        int d0, e0, r0;
        bit ok;
        d0 = done_cnt; e0 = err_cnt; r0 = rise_cnt;
        tcal1 = 9'd64; tcal2 = 9'd32;
        sif.sym_data = 2'b00; sif.sym_last = 1'b0; sif.sym_valid = 1'b1;
        start = 1'b1;
        @(posedge dec_clk); #1;
        start = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge dec_clk);
            ok = (rise_cnt != r0);
        end
        chk("abort_tcal1_reached", int'(ok), 1);
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge dec_clk);
            ok = (dout == 1'b0);
        end
        chk("abort_tcal1_low_reached", int'(ok), 1);
        @(posedge dec_clk); #1;
        abort = 1'b1;
        @(posedge dec_clk); #1;
        abort = 1'b0;
        start = 1'b1;
        @(negedge dec_clk);
        chk("abort_dout", int'(dout), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_sym_ready", int'(sif.sym_ready), 0);
        @(posedge dec_clk); #1;
        start = 1'b0;
        @(negedge dec_clk);
        chk("abort_restart_busy", int'(busy), 1);
        chk("abort_restart_delim", int'(dout), 0);
        @(posedge dec_clk); #1;
        abort = 1'b1;
        @(posedge dec_clk); #1;
        abort = 1'b0;
        sif.sym_valid = 1'b0;
        @(negedge dec_clk);
        chk("abort2_busy", int'(busy), 0);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_no_err", err_cnt - e0, 0);
        repeat (2) @(posedge dec_clk);
        #1;
    endtask

    initial begin
        vec_t vt[4];
        cfg_t ct[6];

        vt[0] = '{t1: 64, t2: 32, n: 4, code: {2'b10, 2'b11, 2'b01, 2'b00},
                  len: {10'd44, 10'd36, 10'd28, 10'd20}, busy: 249};
        vt[1] = '{t1: 100, t2: 40, n: 2, code: {2'b00, 2'b00, 2'b11, 2'b10},
                  len: {10'd0, 10'd0, 10'd50, 10'd60}, busy: 275};
        vt[2] = '{t1: 40, t2: 16, n: 3, code: {2'b00, 2'b10, 2'b00, 2'b01},
                  len: {10'd0, 10'd24, 10'd12, 10'd16}, busy: 133};
        vt[3] = '{t1: 200, t2: 100, n: 1, code: {2'b00, 2'b00, 2'b00, 2'b11},
                  len: {10'd0, 10'd0, 10'd0, 10'd112}, busy: 437};

        ct[0] = '{t1: 64, t2: 4,  bad: 1'b1};
        ct[1] = '{t1: 32, t2: 32, bad: 1'b1};
        ct[2] = '{t1: 20, t2: 30, bad: 1'b1};
        ct[3] = '{t1: 64, t2: 7,  bad: 1'b1};
        ct[4] = '{t1: 9,  t2: 8,  bad: 1'b0};
        ct[5] = '{t1: 64, t2: 32, bad: 1'b0};

        sif.sym_data  = 2'b00;
        sif.sym_valid = 1'b0;
        sif.sym_last  = 1'b0;

        repeat (3) @(posedge dec_clk);
        @(negedge dec_clk);
        chk("reset_dout", int'(dout), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_sym_ready", int'(sif.sym_ready), 0);
        @(posedge dec_clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge dec_clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            tcal1 = 9'(ct[i].t1);
            tcal2 = 9'(ct[i].t2);
            start = 1'b1;
            @(posedge dec_clk); #1;
            start = 1'b0;
            @(negedge dec_clk);
            chk($sformatf("cfg%0d_err", i), int'(err), int'(ct[i].bad));
            chk($sformatf("cfg%0d_busy", i), int'(busy), int'(!ct[i].bad));
            chk($sformatf("cfg%0d_dout", i), int'(dout), int'(ct[i].bad));
            if (!ct[i].bad) begin
                @(posedge dec_clk); #1;
                abort = 1'b1;
                @(posedge dec_clk); #1;
                abort = 1'b0;
                @(negedge dec_clk);
                chk($sformatf("cfg%0d_abort_busy", i), int'(busy), 0);
            end
            @(posedge dec_clk); #1;
        end

        for (int i = 0; i < 4; i++)
            run_frame(vt[i], -1, $sformatf("frame%0d", i));

        run_frame(vt[0], 1, "underrun");

        abort_seq();

        abort = 1'b1;
        @(posedge dec_clk); #1;
        abort = 1'b0;
        @(negedge dec_clk);
        chk("idle_abort_busy", int'(busy), 0);
        chk("idle_abort_dout", int'(dout), 1);
        chk("idle_abort_err", int'(err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tpp_encoder.md
Name: tpp_encoder

Overview:
Reader-side TPP (pulse-position) transmitter, the counterpart of the baseband TPP decoder. It serialises one frame onto a single line: a delimiter, the Tcal1 and Tcal2 calibration symbols, then 2-bit data symbols. Each symbol's length is measured rising-edge to rising-edge. The block sits between the command-assembly logic (a symbol stream with a valid/ready handshake) and the modulator line driver, and runs on the same 1.92 MHz-class domain.

Parameters:
DELIM_LEN, 24, delimiter low time in cycles (>=2)
LOW_W, 6, low-pulse width in cycles at the end of every non-delimiter symbol
EOF_LEN, 320, high hold after the last symbol (only with TPP_ENC_EOF_EN)

Ports:
dec_clk  in  1  block clock; all logic rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a frame; sampled only in IDLE
tcal1  in  9  Tcal1 length in cycles; latched on accepted start
tcal2  in  9  Tcal2 length in cycles; latched on accepted start
sym_data  in  2  next data symbol
sym_valid  in  1  sym_data valid
sym_last  in  1  marks the final symbol of the frame
sym_ready  out  1  symbol accepted this cycle
abort  in  1  synchronous frame kill
dout  out  1  TPP line; idle high
busy  out  1  high while not in IDLE
done  out  1  one-cycle frame-complete pulse
err  out  1  one-cycle pulse on config error or underrun

Behaviour:
- Reset values: dout=1, busy=0, done=0, err=0, sym_ready=0; FSM in IDLE; all counters 0.
- All outputs are registered.
- FSM states: IDLE, DELIM, TCAL1, TCAL2, DATA, EOF (EOF exists only with the macro).
- Config check on start in IDLE: cfg_ok = (tcal2 >= 8) and (tcal1 > tcal2) and (tcal2 > LOW_W).
  - If cfg_ok=0: err pulses next cycle and the FSM stays in IDLE.
  - If cfg_ok=1: latch tcal1 and tcal2, go to DELIM.
- DELIM: dout=0 for DELIM_LEN cycles, starting the cycle after start is accepted.
- Segment of length D (TCAL1 D=tcal1, TCAL2 D=tcal2, DATA D=len(code)): dout=1 for D-LOW_W cycles, then dout=0 for LOW_W cycles. Every segment boundary is a 0->1 edge on dout.
- Data symbol length (10-bit arithmetic, truncating shifts):
  - base = tcal1>>2 + tcal2>>3; step = tcal2>>2.
  - Rank order 00=0, 01=1, 11=2, 10=3 (Gray); len = base + rank*step.
  - Each symbol lands mid-way between the decoder pivots.
- Fetch rule: on the last cycle of TCAL2 and of each non-last DATA segment, the block samples sym_valid.
  - valid=1: sym_ready=1 that same cycle; code and last flag are captured; the next segment is DATA.
  - valid=0 (underrun): err pulses, dout returns to 1, FSM goes to IDLE, no done.
- Last data segment end: without the macro, done pulses the cycle after the final rising edge and the FSM goes to IDLE. With the macro, the FSM goes to EOF instead.
- abort=1 in any non-IDLE state: next cycle dout=1, FSM=IDLE, sym_ready=0, no done/err; abort has priority over everything.
- abort in IDLE is ignored.
- start while busy is ignored.
- sym_valid outside fetch cycles is ignored; sym_ready never asserts outside fetch cycles.
- A frame with zero data symbols is not supported; the first fetch is mandatory.

Optional Feature:
TPP_ENC_EOF_EN
- Defined: after the last symbol the FSM holds EOF with dout=1 for EOF_LEN cycles, then pulses done. EOF_LEN exceeds the decoder's 310-count symbol timeout, so the far end is guaranteed to terminate decoding.
- Undefined: the EOF state and counter are absent; done follows the final rising edge immediately.

Decomposition:
- Package tpp_pkg holds:
  - the FSM state encoding;
  - the code-to-rank mapping (00->0, 01->1, 11->2, 10->3);
  - the default constants for DELIM_LEN, LOW_W, EOF_LEN;
  - the minimum tcal2 value (8).
- One sub-module, tpp_seg_timer: it loads length D, down-counts, drives the high/low shape and emits seg_last (last cycle) to the FSM.
- Symbol-length arithmetic stays in the top level.

Test Plan:
- Nominal frame: tcal1=64, tcal2=32, symbols 00,01,11,10 (last on 10) -> dout low 24 cycles, then rising-edge intervals 64, 32, 20, 28, 36, 44; each segment low for its final 6 cycles; 4 sym_ready pulses; done one cycle after the last edge; busy length 1+24+64+32+128.
- Loop-back: encoder dout into the TPP decoder with 64/32 and random symbols -> decoder tpp_data matches the sent codes in order; TC_val=16.
- Underrun: sym_valid=0 at the second fetch -> err pulse; dout=1 and FSM in IDLE the next cycle; no done; exactly 1 sym_ready.
- Bad config: start with tcal2=4 -> err pulse; busy stays 0; dout stays 1.
- Abort mid-TCAL1 while dout is low -> dout=1 next cycle; busy=0; no done/err; a new start 1 cycle later is accepted.
- EOF (macro on): nominal frame -> dout held high 320 cycles after the last edge, then done; macro off -> done immediately after the last edge.
